// File: rtl/uart_rx_fifo_core.sv
// UART receive engine (5..DW data bits, parity, 1/2 stop, 2-of-3 voting, break) feeding a show-ahead RX FIFO.
// Latency: character pushed one clk after its final stop decision; level/flags follow on the next edge.
// Backpressure: none toward the line; a push into a full FIFO without a same-cycle rd is dropped with an overrun pulse.
module uart_rx_fifo_core #(
  parameter int DW      = 9,
  parameter int FIFO_AW = 4,
  parameter int OVS     = 16,
  parameter int PSW     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  input  logic [PSW-1:0]     prescaler,
  input  logic [3:0]         data_bits,
  input  logic [2:0]         parity_mode,
  input  logic               stop2,
  input  logic               rx,
  input  logic               rd,
  input  logic [FIFO_AW:0]   threshold,
  output logic [DW-1:0]      rdata,
  output logic [FIFO_AW:0]   level,
  output logic               empty,
  output logic               full,
  output logic               above,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overrun,
  output logic               break_det
);

  localparam int TW    = $clog2(OVS);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [TW-1:0]    LP_S0    = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0]    LP_S1    = TW'(OVS / 2);
  localparam logic [TW-1:0]    LP_DEC   = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0]    LP_END   = TW'(OVS - 1);
  localparam logic [3:0]       LP_DW    = 4'(DW);
  localparam logic [FIFO_AW:0] LP_DEPTH = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRKWAIT
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rxs;
  logic [PSW-1:0]       r_ps_cnt;
  logic [TW-1:0]        r_tcnt;
  logic                 r_s0, r_s1;
  logic [DW-1:0]        r_shift;
  logic [3:0]           r_bitcnt;
  logic                 r_par_err, r_par_bit;
  logic                 r_push_pend;
  logic [DW-1:0]        r_push_dat;
  logic                 r_fe, r_pe, r_ov, r_bk;
  logic [DW-1:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]     r_level;

  logic                 w_tick, w_dec, w_bend, w_maj;
  logic [3:0]           w_nbits;
  logic                 w_par_en, w_par_exp, w_zero;
  logic                 w_shift_en, w_par_chk, w_fin, w_ferr, w_brk;
  logic                 w_empty, w_full, w_pop, w_wr, w_ovr;

  // Runtime frame configuration: clamp width, decode parity mode, expected parity bit
  assign w_nbits   = (data_bits < 4'd5) ? 4'd5 : ((data_bits > LP_DW) ? LP_DW : data_bits);
  assign w_par_en  = (parity_mode >= 3'd1) && (parity_mode <= 3'd4);
  assign w_par_exp = (parity_mode == 3'd1) ? ~(^r_shift) :
                     (parity_mode == 3'd2) ?  (^r_shift) :
                     (parity_mode == 3'd4);
  // Break candidate: every data bit and the parity bit (when present) sampled low
  assign w_zero    = (r_shift == '0) && (!w_par_en || !r_par_bit);

  // Bit timing strobes; the third vote is the live synchronised sample
  assign w_tick = en && (r_state != S_IDLE) && (r_ps_cnt == '0);
  assign w_dec  = w_tick && (r_tcnt == LP_DEC);
  assign w_bend = w_tick && (r_tcnt == LP_END);
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

  // Two-flop synchroniser on the asynchronous serial input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // Baud prescaler: down-counter, tick at zero, held cleared while idle or disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_ps_cnt <= '0;
    else if (!en || r_state == S_IDLE)      r_ps_cnt <= '0;
    else if (r_ps_cnt == '0)                r_ps_cnt <= prescaler;
    else                                    r_ps_cnt <= r_ps_cnt - 1'b1;
  end

  // Oversample position within the bit plus the two early votes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else begin
      if (!en || r_state == S_IDLE || r_state == S_BRKWAIT) r_tcnt <= '0;
      else if (w_tick) r_tcnt <= (r_tcnt == LP_END) ? '0 : r_tcnt + 1'b1;
      if (w_tick && r_tcnt == LP_S0) r_s0 <= r_rxs;
      if (w_tick && r_tcnt == LP_S1) r_s1 <= r_rxs;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; disabling the receiver abandons any partial frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!r_rxs) w_state_nxt = S_START;
      S_START:   if (w_dec && w_maj) w_state_nxt = S_IDLE;
                 else if (w_bend) w_state_nxt = S_DATA;
      S_DATA:    if (w_bend && r_bitcnt == w_nbits) w_state_nxt = w_par_en ? S_PARITY : S_STOP1;
      S_PARITY:  if (w_bend) w_state_nxt = S_STOP1;
      S_STOP1:   if (w_brk) w_state_nxt = S_BRKWAIT;
                 else if (w_ferr || w_fin) w_state_nxt = S_IDLE;
                 else if (w_bend) w_state_nxt = S_STOP2;
      S_STOP2:   if (w_ferr || w_fin) w_state_nxt = S_IDLE;
      S_BRKWAIT: if (r_rxs) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (!en) w_state_nxt = S_IDLE;
  end

  // FSM outputs: per-state strobes taken at the mid-bit majority decision
  always_comb begin
    w_shift_en = 1'b0;
    w_par_chk  = 1'b0;
    w_fin      = 1'b0;
    w_ferr     = 1'b0;
    w_brk      = 1'b0;
    case (r_state)
      S_DATA:   w_shift_en = w_dec;
      S_PARITY: w_par_chk  = w_dec;
      S_STOP1: begin
        w_brk  = w_dec && !w_maj && w_zero;
        w_ferr = w_dec && !w_maj && !w_zero;
        w_fin  = w_dec && w_maj && !stop2;
      end
      S_STOP2: begin
        w_ferr = w_dec && !w_maj;
        w_fin  = w_dec && w_maj;
      end
      default: ;
    endcase
  end

  // Receive datapath: LSB-first right-aligned shift, parity latch, push and pulse staging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_par_err   <= 1'b0;
      r_par_bit   <= 1'b0;
      r_push_pend <= 1'b0;
      r_push_dat  <= '0;
      r_fe        <= 1'b0;
      r_pe        <= 1'b0;
      r_bk        <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_shift   <= '0;
        r_bitcnt  <= '0;
        r_par_err <= 1'b0;
        r_par_bit <= 1'b0;
      end else begin
        if (w_shift_en) begin
          r_shift[r_bitcnt] <= w_maj;
          r_bitcnt          <= r_bitcnt + 4'd1;
        end
        if (w_par_chk) begin
          r_par_bit <= w_maj;
          r_par_err <= (w_maj != w_par_exp);
        end
      end
      r_push_pend <= w_fin && !r_par_err;
      r_push_dat  <= r_shift;
      r_pe        <= w_fin && r_par_err;
      r_fe        <= w_ferr;
      r_bk        <= w_brk;
    end
  end

  // FIFO control: flush beats rd and drops a coincident push; full+rd still accepts a push
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LP_DEPTH);
  assign w_pop   = rd && !w_empty;
  assign w_wr    = r_push_pend && !flush && (!w_full || w_pop);
  assign w_ovr   = r_push_pend && !flush && w_full && !rd;

  // FIFO pointers, occupancy and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ov     <= 1'b0;
    end else begin
      r_ov <= w_ovr;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_wr, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // FIFO storage; contents are only observable through valid pointers
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_dat;
  end

  assign rdata      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level      = r_level;
  assign empty      = w_empty;
  assign full       = w_full;
  assign above      = (r_level > threshold);
  assign frame_err  = r_fe;
  assign parity_err = r_pe;
  assign overrun    = r_ov;
  assign break_det  = r_bk;

endmodule
